// File: rtl/cpu_check_pkg.sv
// Shared encodings for the CPU result checker: FSM states, done reasons and
// per-entry grading status codes.
package cpu_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DR_NONE    = 2'd0,
    DR_ALL     = 2'd1,
    DR_HALT    = 2'd2,
    DR_TIMEOUT = 2'd3
  } reason_e;

  typedef enum logic [1:0] {
    SC_NO_RESULT = 2'd0,
    SC_PASS      = 2'd1,
    SC_WRONG     = 2'd2,
    SC_MISSED    = 2'd3
  } stat_e;

endpackage

// File: rtl/cpu_result_checker_if.sv
// Control, table-load, CPU-observation and status bundle of the result checker.
// The checker takes the slave side; the harness driving it takes master.
interface cpu_result_checker_if #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_W     = 6,
  parameter int CYC_W     = 16
);
  logic                 tbl_we;
  logic [IDX_W-1:0]     tbl_addr;
  logic [WORD_SIZE-1:0] tbl_num_inst;
  logic [WORD_SIZE-1:0] tbl_ans;
  logic                 start;
  logic [IDX_W:0]       num_tests;
  logic [WORD_SIZE-1:0] num_inst;
  logic [WORD_SIZE-1:0] output_port;
  logic                 is_halted;
  logic [IDX_W-1:0]     stat_addr;

  logic                 busy;
  logic                 done;
  logic [1:0]           done_reason;
  logic                 all_pass;
  logic [IDX_W:0]       pass_count;
  logic [IDX_W:0]       fail_count;
  logic [IDX_W:0]       miss_count;
  logic [CYC_W-1:0]     cycle_count;
  logic                 fail_valid;
  logic [IDX_W-1:0]     fail_idx;
  logic [WORD_SIZE-1:0] fail_got;
  logic [1:0]           stat_code;

  modport master (
    output tbl_we, tbl_addr, tbl_num_inst, tbl_ans, start, num_tests,
           num_inst, output_port, is_halted, stat_addr,
    input  busy, done, done_reason, all_pass, pass_count, fail_count,
           miss_count, cycle_count, fail_valid, fail_idx, fail_got, stat_code
  );

  modport slave (
    input  tbl_we, tbl_addr, tbl_num_inst, tbl_ans, start, num_tests,
           num_inst, output_port, is_halted, stat_addr,
    output busy, done, done_reason, all_pass, pass_count, fail_count,
           miss_count, cycle_count, fail_valid, fail_idx, fail_got, stat_code
  );
endinterface

// File: rtl/test_vector_ram.sv
// Expected-result table: one synchronous write port, one asynchronous read port.
// Deliberately not reset so a loaded table survives checker resets.
module test_vector_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cpu_result_checker.sv
// Grades CPU debug outputs against a loaded table of (num_inst, output_port)
// pairs, one entry per cycle at most, and stops on completion, halt or timeout.
module cpu_result_checker
  import cpu_check_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_TEST   = 64,
  parameter int IDX_W      = 6,
  parameter int MAX_CYCLES = 10000,
  parameter int CYC_W      = 16
) (
  input logic             clk,
  input logic             reset,
  cpu_result_checker_if.slave bus
);
  localparam logic [IDX_W:0]   NT_MAX  = (IDX_W+1)'(NUM_TEST);
  localparam logic [CYC_W-1:0] CYC_END = CYC_W'(MAX_CYCLES - 1);

  state_e                       state_q, state_d;
  reason_e                      reason_q, reason_d;
  logic [IDX_W:0]               ptr_q, ptr_d;
  logic [IDX_W:0]               ntests_q, ntests_d;
  logic [IDX_W:0]               pass_q, pass_d;
  logic [IDX_W:0]               fail_q, fail_d;
  logic [IDX_W:0]               miss_q, miss_d;
  logic [CYC_W-1:0]             cyc_q, cyc_d;
  logic                         fvld_q, fvld_d;
  logic [IDX_W-1:0]             fidx_q, fidx_d;
  logic [WORD_SIZE-1:0]         fgot_q, fgot_d;
  logic [NUM_TEST-1:0][1:0]     status_q, status_d;
  logic [1:0]                   stat_q;

  logic [2*WORD_SIZE-1:0]       rd_entry;
  logic [WORD_SIZE-1:0]         exp_ni, exp_ans;
  logic [IDX_W-1:0]             idx;

  assign idx     = ptr_q[IDX_W-1:0];
  assign exp_ni  = rd_entry[2*WORD_SIZE-1:WORD_SIZE];
  assign exp_ans = rd_entry[WORD_SIZE-1:0];

  // Writes are blocked only while running, so a load alongside start lands first.
  test_vector_ram #(
    .DEPTH (NUM_TEST),
    .AW    (IDX_W),
    .DW    (2*WORD_SIZE)
  ) u_ram (
    .clk     (clk),
    .we_i    (bus.tbl_we && (state_q != ST_RUN)),
    .waddr_i (bus.tbl_addr),
    .wdata_i ({bus.tbl_num_inst, bus.tbl_ans}),
    .raddr_i (idx),
    .rdata_o (rd_entry)
  );

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    ptr_d    = ptr_q;
    ntests_d = ntests_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    miss_d   = miss_q;
    cyc_d    = cyc_q;
    fvld_d   = 1'b0;
    fidx_d   = fidx_q;
    fgot_d   = fgot_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          ptr_d    = '0;
          pass_d   = '0;
          fail_d   = '0;
          miss_d   = '0;
          cyc_d    = '0;
          fidx_d   = '0;
          fgot_d   = '0;
          status_d = '0;
          reason_d = DR_NONE;
          ntests_d = (bus.num_tests > NT_MAX) ? NT_MAX : bus.num_tests;
          if (ntests_d == '0) begin
            state_d  = ST_DONE;
            reason_d = DR_ALL;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (ptr_q < ntests_q) begin
          if (bus.num_inst == exp_ni) begin
            if (bus.output_port == exp_ans) begin
              status_d[idx] = SC_PASS;
              if (pass_q != '1) pass_d = pass_q + 1'b1;
            end else begin
              status_d[idx] = SC_WRONG;
              if (fail_q != '1) fail_d = fail_q + 1'b1;
              fvld_d = 1'b1;
              fidx_d = idx;
              fgot_d = bus.output_port;
            end
            ptr_d = ptr_q + 1'b1;
          end else if (bus.num_inst > exp_ni) begin
            status_d[idx] = SC_MISSED;
            if (miss_q != '1) miss_d = miss_q + 1'b1;
            ptr_d = ptr_q + 1'b1;
          end
        end
        // Termination is judged on post-grading values, completion first.
        if (ptr_d == ntests_q) begin
          state_d  = ST_DONE;
          reason_d = DR_ALL;
        end else if (bus.is_halted) begin
          state_d  = ST_DONE;
          reason_d = DR_HALT;
        end else if (cyc_d == CYC_END) begin
          state_d  = ST_DONE;
          reason_d = DR_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      reason_q <= DR_NONE;
      ptr_q    <= '0;
      ntests_q <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      miss_q   <= '0;
      cyc_q    <= '0;
      fvld_q   <= 1'b0;
      fidx_q   <= '0;
      fgot_q   <= '0;
      status_q <= '0;
      stat_q   <= '0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      ptr_q    <= ptr_d;
      ntests_q <= ntests_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      miss_q   <= miss_d;
      cyc_q    <= cyc_d;
      fvld_q   <= fvld_d;
      fidx_q   <= fidx_d;
      fgot_q   <= fgot_d;
      status_q <= status_d;
      stat_q   <= status_q[bus.stat_addr];
    end
  end

  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.done_reason = reason_q;
  assign bus.all_pass    = (state_q == ST_DONE) && (pass_q == ntests_q);
  assign bus.pass_count  = pass_q;
  assign bus.fail_count  = fail_q;
  assign bus.miss_count  = miss_q;
  assign bus.cycle_count = cyc_q;
  assign bus.fail_valid  = fvld_q;
  assign bus.fail_idx    = fidx_q;
  assign bus.fail_got    = fgot_q;
  assign bus.stat_code   = stat_q;
endmodule

// File: tb/tb_cpu_result_checker.sv
// Directed bench for cpu_result_checker: short runs covering grading, halt,
// timeout, write-blocking, same-cycle load+start and mid-run reset.
module tb_cpu_result_checker;
  localparam int WS = 16;
  localparam int NT = 8;
  localparam int IW = 3;
  localparam int MC = 20;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cpu_result_checker_if #(.WORD_SIZE(WS), .IDX_W(IW), .CYC_W(CW)) bus ();

  cpu_result_checker #(
    .WORD_SIZE (WS),
    .NUM_TEST  (NT),
    .IDX_W     (IW),
    .MAX_CYCLES(MC),
    .CYC_W     (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input int ni, input int ans);
    bus.tbl_we       = 1'b1;
    bus.tbl_addr     = IW'(a);
    bus.tbl_num_inst = WS'(ni);
    bus.tbl_ans      = WS'(ans);
    tick();
    bus.tbl_we = 1'b0;
  endtask

  task automatic go(input int n);
    bus.start     = 1'b1;
    bus.num_tests = (IW+1)'(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic cpu(input int ni, input int op, input logic h);
    bus.num_inst    = WS'(ni);
    bus.output_port = WS'(op);
    bus.is_halted   = h;
    tick();
  endtask

  initial begin
    reset            = 1'b1;
    bus.tbl_we       = 1'b0;
    bus.tbl_addr     = '0;
    bus.tbl_num_inst = '0;
    bus.tbl_ans      = '0;
    bus.start        = 1'b0;
    bus.num_tests    = '0;
    bus.num_inst     = '0;
    bus.output_port  = '0;
    bus.is_halted    = 1'b0;
    bus.stat_addr    = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_reason", 32'(bus.done_reason), 0);
    chk("rst_all_pass", 32'(bus.all_pass), 0);
    chk("rst_cycles", 32'(bus.cycle_count), 0);
    chk("rst_stat", 32'(bus.stat_code), 0);

    // Two passing entries.
    load(0, 3, 'h0000);
    load(1, 5, 'h0001);
    go(2);
    chk("t1_busy", 32'(bus.busy), 1);
    for (int i = 0; i <= 5; i++) cpu(i, (i >= 5) ? 1 : 0, 1'b0);
    chk("t1_pass", 32'(bus.pass_count), 2);
    chk("t1_reason", 32'(bus.done_reason), 1);
    chk("t1_all_pass", 32'(bus.all_pass), 1);
    chk("t1_cycles", 32'(bus.cycle_count), 6);
    chk("t1_fail", 32'(bus.fail_count), 0);
    bus.stat_addr = 3'd1;
    tick();
    chk("t1_stat1", 32'(bus.stat_code), 1);

    // Wrong output at a matching count (re-run from DONE).
    load(0, 4, 'h0002);
    go(1);
    bus.stat_addr = 3'd0;
    cpu(2, 'h0002, 1'b0);
    chk("t2_no_pulse_early", 32'(bus.fail_valid), 0);
    cpu(4, 'h0007, 1'b0);
    chk("t2_fail_valid", 32'(bus.fail_valid), 1);
    chk("t2_fail_idx", 32'(bus.fail_idx), 0);
    chk("t2_fail_got", 32'(bus.fail_got), 'h0007);
    chk("t2_fail_count", 32'(bus.fail_count), 1);
    chk("t2_all_pass", 32'(bus.all_pass), 0);
    tick();
    chk("t2_pulse_once", 32'(bus.fail_valid), 0);
    chk("t2_stat0", 32'(bus.stat_code), 2);

    // Count jumps past two entries: missed on consecutive cycles.
    load(0, 4, 0);
    load(1, 6, 0);
    go(2);
    cpu(3, 0, 1'b0);
    cpu(7, 0, 1'b0);
    chk("t3_miss1", 32'(bus.miss_count), 1);
    chk("t3_busy", 32'(bus.busy), 1);
    cpu(7, 0, 1'b0);
    chk("t3_miss2", 32'(bus.miss_count), 2);
    chk("t3_reason", 32'(bus.done_reason), 1);
    chk("t3_pass", 32'(bus.pass_count), 0);
    chk("t3_all_pass", 32'(bus.all_pass), 0);

    // Halt before the second entry is reached.
    load(0, 3, 'h00AA);
    load(1, 9, 'h00BB);
    go(2);
    cpu(3, 'h00AA, 1'b0);
    chk("t4_pass", 32'(bus.pass_count), 1);
    cpu(5, 'h00AA, 1'b1);
    chk("t4_reason", 32'(bus.done_reason), 2);
    chk("t4_done", 32'(bus.done), 1);
    chk("t4_all_pass", 32'(bus.all_pass), 0);
    bus.stat_addr = 3'd1;
    cpu(9, 'h00BB, 1'b0);
    chk("t4_stat1", 32'(bus.stat_code), 0);
    chk("t4_frozen_pass", 32'(bus.pass_count), 1);

    // Empty run completes immediately with everything passing.
    go(0);
    tick();
    chk("t0_done", 32'(bus.done), 1);
    chk("t0_reason", 32'(bus.done_reason), 1);
    chk("t0_all_pass", 32'(bus.all_pass), 1);

    // Timeout; a table write attempted mid-run must be ignored.
    load(0, 100, 0);
    go(1);
    bus.num_inst    = '0;
    bus.output_port = '0;
    bus.is_halted   = 1'b0;
    repeat (5) tick();
    load(0, 0, 0);
    repeat (12) tick();
    chk("t5_busy", 32'(bus.busy), 1);
    chk("t5_cycles18", 32'(bus.cycle_count), 18);
    chk("t5_no_write", 32'(bus.pass_count), 0);
    tick();
    chk("t5_done", 32'(bus.done), 1);
    chk("t5_reason", 32'(bus.done_reason), 3);
    chk("t5_cycles", 32'(bus.cycle_count), 19);

    // Same-cycle load and start, then reset mid-run, then a clean re-run.
    load(1, 5, 1);
    bus.tbl_we       = 1'b1;
    bus.tbl_addr     = 3'd0;
    bus.tbl_num_inst = 16'd3;
    bus.tbl_ans      = 16'h0000;
    bus.start        = 1'b1;
    bus.num_tests    = 4'd2;
    tick();
    bus.tbl_we = 1'b0;
    bus.start  = 1'b0;
    for (int i = 0; i <= 3; i++) cpu(i, 0, 1'b0);
    chk("t6_pass_mid", 32'(bus.pass_count), 1);
    chk("t6_busy_mid", 32'(bus.busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_done", 32'(bus.done), 0);
    chk("t6_rst_pass", 32'(bus.pass_count), 0);
    chk("t6_rst_cycles", 32'(bus.cycle_count), 0);
    chk("t6_rst_stat", 32'(bus.stat_code), 0);
    go(2);
    for (int i = 0; i <= 5; i++) cpu(i, (i >= 5) ? 1 : 0, 1'b0);
    chk("t6_pass", 32'(bus.pass_count), 2);
    chk("t6_reason", 32'(bus.done_reason), 1);
    chk("t6_all_pass", 32'(bus.all_pass), 1);
    chk("t6_cycles", 32'(bus.cycle_count), 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
